// File: rtl/iir_pkg.sv
// Shared configuration, state encoding and output conversion for the IIR MAC filter.
package iir_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned COEF_W    = 16;
    localparam int unsigned FRAC_W    = 10;
    localparam int unsigned MAX_ORDER = 4;

    localparam int unsigned ORD_W  = $clog2(MAX_ORDER + 1);
    localparam int unsigned TAP_W  = $clog2(2 * MAX_ORDER + 1);
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = DATA_W + COEF_W + TAP_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(2 ** (FRAC_W - 1));

    typedef struct packed {
        logic              sat;
        logic [DATA_W-1:0] data;
    } sat_res_t;

    // Round half-up on the fractional bits, then clip to the sample range.
    function automatic sat_res_t sat_round(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        sat_res_t                res;
        r = (acc + RND) >>> FRAC_W;
        if (r > SAT_MAX) begin
            res.sat  = 1'b1;
            res.data = SAT_MAX[DATA_W-1:0];
        end else if (r < SAT_MIN) begin
            res.sat  = 1'b1;
            res.data = SAT_MIN[DATA_W-1:0];
        end else begin
            res.sat  = 1'b0;
            res.data = r[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/iir_mac_filter_if.sv
// Sample handshake, coefficient port and result bus of the IIR MAC filter.
interface iir_mac_filter_if;
    import iir_pkg::*;

    logic [ORD_W-1:0]  order;
    logic              coef_we;
    logic              coef_sel;
    logic [ORD_W-1:0]  coef_idx;
    logic [COEF_W-1:0] coef_data;
    logic              coef_err;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              sat_flag;
    logic              busy;

    modport master (
        output order, coef_we, coef_sel, coef_idx, coef_data, in_valid, in_data,
        input  coef_err, in_ready, out_valid, out_data, sat_flag, busy
    );

    modport slave (
        input  order, coef_we, coef_sel, coef_idx, coef_data, in_valid, in_data,
        output coef_err, in_ready, out_valid, out_data, sat_flag, busy
    );

endinterface

// File: rtl/iir_mac_unit.sv
// Single signed multiply-accumulate; one product per enabled cycle, add or subtract.
module iir_mac_unit
    import iir_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic                     sub_i,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic signed [DATA_W-1:0] data_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;

    assign prod     = PROD_W'(coef_i) * PROD_W'(data_i);
    assign prod_ext = ACC_W'(prod);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sub_i ? (acc_q - prod_ext) : (acc_q + prod_ext);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/iir_mac_filter.sv
// Time-multiplexed direct-form-I IIR: FSM, tap sequencer, coefficient banks, histories.
module iir_mac_filter
    import iir_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    iir_mac_filter_if.slave  bus
);

    localparam logic [ORD_W-1:0] MAX_ORD = ORD_W'(MAX_ORDER);

    logic [1:0]        state_q, state_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic [ORD_W-1:0]  ord_q, ord_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] xh_q [1:MAX_ORDER];
    logic [DATA_W-1:0] xh_d [1:MAX_ORDER];
    logic [DATA_W-1:0] yh_q [1:MAX_ORDER];
    logic [DATA_W-1:0] yh_d [1:MAX_ORDER];
    logic [COEF_W-1:0] b_q  [0:MAX_ORDER];
    logic [COEF_W-1:0] b_d  [0:MAX_ORDER];
    logic [COEF_W-1:0] a_q  [1:MAX_ORDER];
    logic [COEF_W-1:0] a_d  [1:MAX_ORDER];
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              sat_q, sat_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              coef_err_q, coef_err_d;

    logic              accept, coef_ok, mac_sub, last_tap;
    logic [COEF_W-1:0] mac_coef;
    logic [DATA_W-1:0] mac_data;
    logic signed [ACC_W-1:0] acc;
    sat_res_t          res;

    assign accept   = (state_q == ST_IDLE) && bus.in_valid;
    assign coef_ok  = (state_q == ST_IDLE) && (bus.coef_idx <= MAX_ORD) &&
                      !(bus.coef_sel && (bus.coef_idx == '0));
    assign last_tap = (tap_q == TAP_W'({ord_q, 1'b0}));
    assign res      = sat_round(acc);

    // Tap k<=N feeds b_k*x[n-k]; tap N+k subtracts a_k*y[n-k].
    always_comb begin
        mac_coef = '0;
        mac_data = '0;
        mac_sub  = 1'b0;
        if (tap_q <= TAP_W'(ord_q)) begin
            if (tap_q == '0) begin
                mac_coef = b_q[0];
                mac_data = x_q;
            end
            for (int unsigned k = 1; k <= MAX_ORDER; k++) begin
                if (tap_q == TAP_W'(k)) begin
                    mac_coef = b_q[k];
                    mac_data = xh_q[k];
                end
            end
        end else begin
            mac_sub = 1'b1;
            for (int unsigned k = 1; k <= MAX_ORDER; k++) begin
                if (tap_q == TAP_W'(ord_q) + TAP_W'(k)) begin
                    mac_coef = a_q[k];
                    mac_data = yh_q[k];
                end
            end
        end
    end

    iir_mac_unit u_mac (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (accept),
        .en_i   (state_q == ST_MAC),
        .sub_i  (mac_sub),
        .coef_i (mac_coef),
        .data_i (mac_data),
        .acc_o  (acc)
    );

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        ord_d       = ord_q;
        x_d         = x_q;
        xh_d        = xh_q;
        yh_d        = yh_q;
        b_d         = b_q;
        a_d         = a_q;
        out_data_d  = out_data_q;
        sat_d       = sat_q;
        out_valid_d = 1'b0;
        coef_err_d  = 1'b0;

        if (bus.coef_we) begin
            if (coef_ok) begin
                for (int unsigned k = 0; k <= MAX_ORDER; k++) begin
                    if (bus.coef_idx == ORD_W'(k)) begin
                        if (!bus.coef_sel)  b_d[k] = bus.coef_data;
                        else if (k != 0)    a_d[k] = bus.coef_data;
                    end
                end
            end else begin
                coef_err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.in_data;
                    ord_d   = (bus.order > MAX_ORD) ? MAX_ORD : bus.order;
                    tap_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                tap_d = tap_q + TAP_W'(1);
                if (last_tap) state_d = ST_OUT;
            end
            ST_OUT: begin
                out_data_d  = res.data;
                sat_d       = res.sat;
                out_valid_d = 1'b1;
                xh_d[1]     = x_q;
                yh_d[1]     = res.data;
                for (int unsigned k = 2; k <= MAX_ORDER; k++) begin
                    xh_d[k] = xh_q[k-1];
                    yh_d[k] = yh_q[k-1];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            ord_q       <= '0;
            x_q         <= '0;
            for (int unsigned k = 1; k <= MAX_ORDER; k++) begin
                xh_q[k] <= '0;
                yh_q[k] <= '0;
                a_q[k]  <= '0;
            end
            for (int unsigned k = 0; k <= MAX_ORDER; k++) b_q[k] <= '0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            coef_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            ord_q       <= ord_d;
            x_q         <= x_d;
            xh_q        <= xh_d;
            yh_q        <= yh_d;
            b_q         <= b_d;
            a_q         <= a_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            coef_err_q  <= coef_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sat_flag  = sat_q;
    assign bus.busy      = busy_q;
    assign bus.coef_err  = coef_err_q;

endmodule

// File: tb/tb_iir_mac_filter.sv
// Self-checking bench for iir_mac_filter against an arithmetic difference-equation model.
module tb_iir_mac_filter;
    import iir_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    iir_mac_filter_if bus ();

    iir_mac_filter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: coefficients and histories as plain integers; xh[k]=x[n-k], yh[k]=y[n-k].
    int bm [0:MAX_ORDER];
    int am [0:MAX_ORDER];
    int xh [0:MAX_ORDER];
    int yh [0:MAX_ORDER];

    task automatic model_clear();
        for (int k = 0; k <= MAX_ORDER; k++) begin
            bm[k] = 0; am[k] = 0; xh[k] = 0; yh[k] = 0;
        end
    endtask

    function automatic int clamp_ord(input int o);
        return (o > int'(MAX_ORDER)) ? int'(MAX_ORDER) : o;
    endfunction

    task automatic model_step(input logic [15:0] x, input int ord,
                              output logic [15:0] y, output logic s);
        longint acc;
        longint r;
        int     n;
        n     = clamp_ord(ord);
        xh[0] = int'($signed(x));
        acc   = 0;
        for (int k = 0; k <= n; k++) acc += longint'(bm[k]) * longint'(xh[k]);
        for (int k = 1; k <= n; k++) acc -= longint'(am[k]) * longint'(yh[k]);
        r = (acc + (longint'(1) <<< (FRAC_W - 1))) >>> FRAC_W;
        s = 1'b0;
        if (r > 32767)       begin r = 32767;  s = 1'b1; end
        else if (r < -32768) begin r = -32768; s = 1'b1; end
        y = r[15:0];
        for (int k = MAX_ORDER; k >= 1; k--) xh[k] = xh[k-1];
        for (int k = MAX_ORDER; k >= 2; k--) yh[k] = yh[k-1];
        yh[1] = int'($signed(y));
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input bit sel, input int idx, input logic [15:0] data);
        bit ok;
        ok            = !(sel && idx == 0) && (idx <= int'(MAX_ORDER));
        bus.coef_we   = 1'b1;
        bus.coef_sel  = sel;
        bus.coef_idx  = ORD_W'(idx);
        bus.coef_data = data;
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        checks++;
        if (bus.coef_err !== !ok) begin
            errors++;
            $display("FAIL coef_err sel=%0d idx=%0d: got %b expected %b", sel, idx, bus.coef_err, !ok);
        end
        if (ok) begin
            if (sel) am[idx] = int'($signed(data));
            else     bm[idx] = int'($signed(data));
        end
    endtask

    task automatic do_sample(input logic [15:0] x, input int ord, input bit mid_write,
                             output logic [15:0] got, output logic got_sat);
        logic [15:0] ey;
        logic        es;
        int          n, lat, guard;
        n     = clamp_ord(ord);
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL in_ready_wait: got %b expected 1", bus.in_ready);
        end
        model_step(x, ord, ey, es);
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        bus.order    = ORD_W'(ord);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_state: got ready=%b busy=%b expected ready=0 busy=1", bus.in_ready, bus.busy);
        end
        lat = 0;
        if (mid_write) begin
            bus.coef_we   = 1'b1;
            bus.coef_sel  = 1'b0;
            bus.coef_idx  = '0;
            bus.coef_data = 16'($urandom);
            @(posedge clk); #1; lat++;
            bus.coef_we = 1'b0;
            checks++;
            if (bus.coef_err !== 1'b1) begin
                errors++;
                $display("FAIL busy_write_err: got %b expected 1", bus.coef_err);
            end
        end
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 2 * n + 2) begin
            errors++;
            $display("FAIL latency ord=%0d: got %0d expected %0d", ord, lat, 2 * n + 2);
        end
        checks++;
        if (bus.out_data !== ey) begin
            errors++;
            $display("FAIL out_data x=%h ord=%0d: got %h expected %h", x, ord, bus.out_data, ey);
        end
        checks++;
        if (bus.sat_flag !== es) begin
            errors++;
            $display("FAIL sat_flag x=%h ord=%0d: got %b expected %b", x, ord, bus.sat_flag, es);
        end
        got     = bus.out_data;
        got_sat = bus.sat_flag;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== ey) begin
            errors++;
            $display("FAIL out_hold: got valid=%b data=%h expected valid=0 data=%h", bus.out_valid, bus.out_data, ey);
        end
    endtask

    task automatic test_reset();
        logic [15:0] g; logic gs;
        apply_reset();
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.sat_flag, bus.busy, bus.coef_err} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b ov=%b od=%h sat=%b busy=%b err=%b expected 1 0 0000 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.sat_flag, bus.busy, bus.coef_err);
        end
        do_sample(16'h0100, 2, 1'b0, g, gs);
        checks++;
        if (g !== 16'h0000) begin
            errors++;
            $display("FAIL zero_coef_impulse: got %h expected 0000", g);
        end
    endtask

    task automatic test_passthrough();
        logic [15:0] g; logic gs;
        apply_reset();
        write_coef(1'b0, 0, 16'h0400);
        do_sample(16'h1234, 0, 1'b0, g, gs);
        checks++;
        if (g !== 16'h1234) begin
            errors++;
            $display("FAIL passthrough: got %h expected 1234", g);
        end
    endtask

    task automatic test_fir();
        logic [15:0] g; logic gs;
        logic [15:0] xin [4];
        logic [15:0] yexp [4];
        xin  = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
        yexp = '{16'h0100, 16'h0100, 16'h0100, 16'h0000};
        apply_reset();
        for (int k = 0; k < 3; k++) write_coef(1'b0, k, 16'h0400);
        for (int i = 0; i < 4; i++) begin
            do_sample(xin[i], 2, 1'b0, g, gs);
            checks++;
            if (g !== yexp[i]) begin
                errors++;
                $display("FIR_FAIL fir[%0d]: got %h expected %h", i, g, yexp[i]);
            end
        end
    endtask

    task automatic test_feedback();
        logic [15:0] g; logic gs;
        logic [15:0] yexp [4];
        yexp = '{16'h0400, 16'h0200, 16'h0100, 16'h0080};
        apply_reset();
        write_coef(1'b0, 0, 16'h0400);
        write_coef(1'b1, 1, 16'hFE00);
        for (int i = 0; i < 4; i++) begin
            do_sample((i == 0) ? 16'h0400 : 16'h0000, 1, 1'b0, g, gs);
            checks++;
            if (g !== yexp[i]) begin
                errors++;
                $display("FAIL feedback[%0d]: got %h expected %h", i, g, yexp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] g; logic gs;
        apply_reset();
        write_coef(1'b0, 0, 16'h7FFF);
        do_sample(16'h7FFF, 0, 1'b0, g, gs);
        checks++;
        if ({gs, g} !== {1'b1, 16'h7FFF}) begin
            errors++;
            $display("FAIL sat_pos: got sat=%b data=%h expected sat=1 data=7fff", gs, g);
        end
        do_sample(16'h8000, 0, 1'b0, g, gs);
        checks++;
        if ({gs, g} !== {1'b1, 16'h8000}) begin
            errors++;
            $display("FAIL sat_neg: got sat=%b data=%h expected sat=1 data=8000", gs, g);
        end
    endtask

    task automatic test_coef_err();
        logic [15:0] g; logic gs;
        apply_reset();
        write_coef(1'b0, 0, 16'h0300);
        write_coef(1'b1, 0, 16'h1111);
        write_coef(1'b0, 5, 16'h2222);
        write_coef(1'b1, 7, 16'h3333);
        write_coef(1'b1, 1, 16'h0100);
        do_sample(16'h0800, 1, 1'b1, g, gs);
        do_sample(16'h0400, 1, 1'b0, g, gs);
    endtask

    task automatic test_back_to_back();
        logic [15:0] ey, x;
        logic        es;
        logic [16:0] expq [$];
        logic [16:0] e;
        int          acc_cnt, ov_cnt;
        bit          took;
        apply_reset();
        write_coef(1'b0, 0, 16'h0400);
        write_coef(1'b0, 1, 16'h0200);
        write_coef(1'b1, 1, 16'h0100);
        x            = 16'($urandom);
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        bus.order    = ORD_W'(1);
        acc_cnt = 0; ov_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            took = 1'b0;
            if (c < 15 && bus.in_ready === 1'b1) begin
                model_step(x, 1, ey, es);
                expq.push_back({es, ey});
                acc_cnt++;
                took = 1'b1;
            end
            if (c == 15) bus.in_valid = 1'b0;
            @(posedge clk); #1;
            if (took) begin
                x           = 16'($urandom);
                bus.in_data = x;
            end
            if (c == 14) bus.in_valid = 1'b0;
            if (bus.out_valid === 1'b1) begin
                ov_cnt++;
                e = (expq.size() > 0) ? expq.pop_front() : 17'h0;
                checks++;
                if ({bus.sat_flag, bus.out_data} !== e) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", ov_cnt, {bus.sat_flag, bus.out_data}, e);
                end
            end
        end
        checks++;
        if (acc_cnt !== 3 || ov_cnt !== 3) begin
            errors++;
            $display("FAIL b2b_count: got acc=%0d out=%0d expected 3 3", acc_cnt, ov_cnt);
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] g; logic gs;
        bit seen;
        apply_reset();
        write_coef(1'b0, 0, 16'h0400);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0555;
        bus.order    = ORD_W'(2);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 16'h0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b ready=%b data=%h expected 0 1 0000", bus.busy, bus.in_ready, bus.out_data);
        end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_out: got out_valid=1 expected 0");
        end
        do_sample(16'h0555, 2, 1'b0, g, gs);
    endtask

    task automatic test_random();
        logic [15:0] g, d, x;
        logic        gs;
        int          v, nw;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            nw = int'($urandom_range(0, 2));
            for (int w = 0; w < nw; w++) begin
                v = int'($urandom_range(0, 2560)) - 1280;
                d = v[15:0];
                if ($urandom_range(0, 7) == 0) d = 16'($urandom);
                write_coef(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), d);
            end
            x = 16'($urandom);
            do_sample(x, int'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0), g, gs);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.order     = '0;
        bus.coef_we   = 1'b0;
        bus.coef_sel  = 1'b0;
        bus.coef_idx  = '0;
        bus.coef_data = '0;
        model_clear();
        test_reset();
        test_passthrough();
        test_fir();
        test_feedback();
        test_saturation();
        test_coef_err();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_mac_filter.md
# iir_mac_filter

Parametrised, time-multiplexed direct-form-I IIR filter of run-time selectable order (0..MAX_ORDER), the successor to the fixed 16-bit filter block. A single multiplier-accumulator serves all taps. Samples arrive over a valid/ready handshake, and coefficients load through a register-write port. Each output is rounded and saturated, and a saturation flag accompanies it. The block sits between the sample source and the output writer in the filter datapath.

## Interface
- DATA_W, 16: sample width, signed two's complement.
- COEF_W, 16: coefficient width, signed.
- FRAC_W, 10: fractional bits of coefficients (Q(COEF_W-FRAC_W).FRAC_W).
- MAX_ORDER, 4: maximum filter order N, ≥1.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- order  in  clog2(MAX_ORDER+1)  requested order, sampled on input acceptance.
- coef_we  in  1  coefficient write strobe.
- coef_sel  in  1  0 = b bank (b0..bN), 1 = a bank (a1..aN).
- coef_idx  in  clog2(MAX_ORDER+1)  coefficient index.
- coef_data  in  COEF_W  coefficient value.
- coef_err  out  1  one-cycle pulse when a write is rejected.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  input sample x[n].
- out_valid  out  1  one-cycle pulse, out_data is new.
- out_data  out  DATA_W  y[n], held until the next out_valid.
- sat_flag  out  1  y[n] was saturated; valid with out_data.
- busy  out  1  computation in progress.

## Operation
- The block computes y[n] = Σ_{k=0..N} b_k·x[n−k] − Σ_{k=1..N} a_k·y[n−k].
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch x and N = min(order, MAX_ORDER), clear the accumulator, go to MAC.
  - MAC: one product per cycle, in the order b0·x[n], b1·x[n−1]..bN·x[n−N], then −a1·y[n−1]..−aN·y[n−N]. That is 2N+1 cycles; go to OUT after the last product.
  - OUT: round, saturate, register out_data/sat_flag, pulse out_valid, shift the histories (x[n] into the x-line, y[n] into the y-line), return to IDLE.
- Accumulator width: ACC_W = DATA_W+COEF_W+clog2(2·MAX_ORDER+1), full precision, no intermediate overflow.
- Output conversion: add 2^(FRAC_W−1), arithmetic shift right by FRAC_W, then saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. sat_flag=1 iff clipping occurred.
- order=0: a single MAC cycle (b0·x); the y-history still updates.
- order>MAX_ORDER: clamped to MAX_ORDER.
- A lowered order keeps the deeper history contents; they are unused, not cleared.
- Coefficient writes:
  - Accepted only in IDLE and take effect for the next sample.
  - Writes while busy, and a-bank writes with idx=0, are dropped and pulse coef_err on the next cycle.
  - idx>MAX_ORDER is dropped with coef_err.
- Reset:
  - Clears all coefficients, both history lines, the accumulator and the state (→ IDLE).
  - Reset during MAC/OUT aborts the sample; no out_valid is produced.
- Reset values: in_ready=1, out_valid=0, out_data=0, sat_flag=0, busy=0, coef_err=0.

## Timing
- Acceptance edge t → out_valid at t+2N+2 (IDLE→MAC takes 1, MAC takes 2N+1, OUT registers).
- in_ready=0 from acceptance until the state returns to IDLE; the next sample can be accepted one cycle after out_valid.
- Throughput: one sample per 2N+3 cycles.
- in_valid held high while busy is not consumed; the source holds data until in_ready.
- busy = (state ≠ IDLE).
- coef_we with in_valid in the same IDLE cycle: the write is applied first, so the new coefficient is used by that sample.

## Structure
- Package iir_pkg holds:
  - the state enum (IDLE, MAC, OUT);
  - localparams ACC_W and the index widths;
  - the saturation/rounding function sat_round(acc) → {sat, data}.
- Sub-module iir_mac_unit: signed multiply, accumulate and clear, one product per cycle. The top holds the FSM, tap sequencer, coefficient banks and history shift registers.

## Test plan
- Reset: assert reset 2 cycles → all outputs at reset values, in_ready=1; impulse with all coefficients 0 → out_data=0.
- Pass-through: b0=0x0400, order=0, x=0x1234 → out_data=0x1234, out_valid 2 cycles after acceptance.
- FIR: order=2, b0=b1=b2=0x0400, a=0, impulse 0x0100 then zeros → 0x0100, 0x0100, 0x0100, 0x0000; latency 6 cycles each.
- Feedback: order=1, b0=0x0400, a1=0xFE00 (−0.5), impulse 0x0400 → 0x0400, 0x0200, 0x0100, 0x0080.
- Saturation: b0=0x7FFF, x=0x7FFF → out_data=0x7FFF, sat_flag=1; x=0x8000 → 0x8000, sat_flag=1.
- Handshake/abort:
  - in_valid held high through busy → exactly one acceptance per in_ready window.
  - coef_we during MAC → coef_err pulse, coefficient unchanged.
  - reset mid-MAC → no out_valid; IDLE next cycle.
